avalon_led_sw_pio: RTL

- Parametrised Avalon-MM slave for board LEDs and slide switches on the HPS lightweight H2F bus.
- Next generation of the plain LED/SW PIO pair, folded into one peripheral.
- Adds per-LED hardware blink, per-switch debounce, edge capture and a maskable interrupt to the HPS.
- Instanced inside soc_system; `leds` and `sw` are exported to the top-level LED/SW pins.

---
 rtl/avalon_led_sw_pio.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/avalon_led_sw_pio.sv
// Avalon-MM LED/switch peripheral: LED drive with per-bit hardware blink,
// debounced switches with edge capture and a maskable level interrupt.
module avalon_led_sw_pio #(
  parameter int LED_W           = 8,
  parameter int SW_W            = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLINK_W         = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  output logic [LED_W-1:0] leds,
  input  logic [SW_W-1:0]  sw
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_LED_OUT      = 3'd0;
  localparam logic [2:0] ADDR_BLINK_MASK   = 3'd1;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_SW_STATE     = 3'd3;
  localparam logic [2:0] ADDR_EDGE_CAP     = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd5;

  logic [LED_W-1:0]   led_out, blink_mask;
  logic [BLINK_W-1:0] blink_period, blink_cnt;
  logic               phase;
  logic [SW_W-1:0]    sw_meta, sw_sync, sw_stable, stable_nxt;
  logic [SW_W-1:0]    edge_cap, irq_mask, edge_clr;
  logic [CNT_W-1:0]   db_cnt     [SW_W];
  logic [CNT_W-1:0]   db_cnt_nxt [SW_W];
  logic [31:0]        rd_mux;
  logic               wr_led_out, wr_blink_mask, wr_blink_period;
  logic               wr_edge_cap, wr_irq_mask;

  // Only the low bits of the write bus reach a register.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  assign wr_led_out      = avs_write && (avs_address == ADDR_LED_OUT);
  assign wr_blink_mask   = avs_write && (avs_address == ADDR_BLINK_MASK);
  assign wr_blink_period = avs_write && (avs_address == ADDR_BLINK_PERIOD);
  assign wr_edge_cap     = avs_write && (avs_address == ADDR_EDGE_CAP);
  assign wr_irq_mask     = avs_write && (avs_address == ADDR_IRQ_MASK);
  assign edge_clr        = wr_edge_cap ? avs_writedata[SW_W-1:0] : '0;

  // Per-bit debounce: accept sync only after DEBOUNCE_CYCLES disagreeing samples.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    stable_nxt = sw_stable;
    for (int i = 0; i < SW_W; i++) begin
      db_cnt_nxt[i] = '0;
      if (sw_sync[i] != sw_stable[i]) begin
        if (db_cnt[i] == CNT_LAST) stable_nxt[i] = sw_sync[i];
        else                       db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_LED_OUT:      rd_mux = 32'(led_out);
      ADDR_BLINK_MASK:   rd_mux = 32'(blink_mask);
      ADDR_BLINK_PERIOD: rd_mux = 32'(blink_period);
      ADDR_SW_STATE:     rd_mux = 32'(sw_stable);
      ADDR_EDGE_CAP:     rd_mux = 32'(edge_cap);
      ADDR_IRQ_MASK:     rd_mux = 32'(irq_mask);
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out      <= '0;
      blink_mask   <= '0;
      blink_period <= '0;
      irq_mask     <= '0;
      edge_cap     <= '0;
      avs_readdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so a read in the
      // same cycle as a write samples the pre-write value.
      if (wr_led_out)      led_out      <= avs_writedata[LED_W-1:0];
      if (wr_blink_mask)   blink_mask   <= avs_writedata[LED_W-1:0];
      if (wr_blink_period) blink_period <= avs_writedata[BLINK_W-1:0];
      if (wr_irq_mask)     irq_mask     <= avs_writedata[SW_W-1:0];
      // A new edge on the same cycle as a clear wins.
      edge_cap <= (edge_cap & ~edge_clr) | (stable_nxt ^ sw_stable);
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (wr_blink_period || (blink_period == '0)) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == blink_period - BLINK_W'(1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_stable <= '0;
      // NOTE: the debounce counters are ordinary flops, not RAM, so they are reset too.
      for (int i = 0; i < SW_W; i++) db_cnt[i] <= '0;
    end else begin
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      sw_stable <= stable_nxt;
      for (int i = 0; i < SW_W; i++) db_cnt[i] <= db_cnt_nxt[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds <= '0;
      irq  <= 1'b0;
    end else begin
      leds <= led_out ^ (blink_mask & {LED_W{phase}});
      irq  <= |(edge_cap & irq_mask);
    end
  end

endmodule
